// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity over a data word; shares its definition with the receive-side checker.
module uart_parity_gen #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  parity
);
   import uart_pkg::*;

   assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_WIDTH bits LSB-first, optional parity, one stop bit.
// Each bit is held CLKS_PER_BIT cycles; requests are ignored while busy.
module uart_tx_frame #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);
   import uart_pkg::*;

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

   state_t                state;
   logic [BW-1:0]         bit_idx;
   logic [CW-1:0]         cyc_cnt;
   logic [DATA_WIDTH-1:0] data_r;
   logic                  par_en_r;
   logic                  par_bit_r;
   logic                  par_next;
   logic                  bit_done;

   uart_parity_gen #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .data    (p_data),
      .par_typ (par_typ),
      .parity  (par_next)
   );

   assign bit_done = (cyc_cnt == CYC_LAST);

   // tx_out is loaded on each transition so the line value is registered
   // and lines up exactly with the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tx_out    <= LINE_IDLE;
         busy      <= 1'b0;
         bit_idx   <= '0;
         cyc_cnt   <= '0;
         data_r    <= '0;
         par_en_r  <= 1'b0;
         par_bit_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx_out  <= LINE_IDLE;
               busy    <= 1'b0;
               bit_idx <= '0;
               cyc_cnt <= '0;
               if (data_valid) begin
                  data_r    <= p_data;
                  par_en_r  <= par_en;
                  par_bit_r <= par_next;
                  state     <= START;
                  tx_out    <= START_BIT;
                  busy      <= 1'b1;
               end
            end
            START: begin
               if (bit_done) begin
                  cyc_cnt <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
                  tx_out  <= data_r[0];
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  cyc_cnt <= '0;
                  if (bit_idx == BIT_LAST) begin
                     if (par_en_r) begin
                        state  <= PARITY;
                        tx_out <= par_bit_r;
                     end else begin
                        state  <= STOP;
                        tx_out <= STOP_BIT;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx_out  <= data_r[bit_idx + 1'b1];
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            PARITY: begin
               if (bit_done) begin
                  cyc_cnt <= '0;
                  state   <= STOP;
                  tx_out  <= STOP_BIT;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_done) begin
                  cyc_cnt <= '0;
                  state   <= IDLE;
                  tx_out  <= LINE_IDLE;
                  busy    <= 1'b0;
               end else begin
                  cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               tx_out <= LINE_IDLE;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench: stimulus queues hand-written bit sequences, a negedge monitor checks the line.
module tb_uart_tx_frame;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] p_data = 8'h00;
   logic       data_valid = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       tx_out;
   logic       busy;

   always #5 clk = ~clk;

   uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .tx_out     (tx_out),
      .busy       (busy)
   );

   int total = 0;
   int bad = 0;

   // Expected frames: bit string in line order (start first), busy length, idle gap before (-1 = any).
   string q_seq[$];
   int    q_len[$];
   int    q_gap[$];

   logic  mon_en = 1'b0;
   bit    in_frame = 1'b0;
   string cur_seq;
   int    cur_len = 0;
   int    cur_gap = -1;
   int    idx = 0;
   int    idle_cnt = 0;
   logic  exp_bit;

   always @(negedge clk) begin
      if (mon_en) begin
         if (!in_frame && busy) begin
            total++;
            if (q_seq.size() == 0) begin
               bad++;
               $display("FAIL unexpected_frame: got busy=1 want no frame pending");
               cur_seq = "";
               cur_len = 0;
               cur_gap = -1;
            end else begin
               cur_seq = q_seq.pop_front();
               cur_len = q_len.pop_front();
               cur_gap = q_gap.pop_front();
            end
            if (cur_gap >= 0) begin
               total++;
               if (idle_cnt != cur_gap) begin
                  bad++;
                  $display("FAIL frame_gap: got %0d idle cycles want %0d", idle_cnt, cur_gap);
               end
            end
            in_frame = 1'b1;
            idx = 0;
         end
         if (in_frame) begin
            total++;
            if (idx < cur_len) begin
               exp_bit = (cur_seq[idx / CPB] == "1");
               if (busy !== 1'b1 || tx_out !== exp_bit) begin
                  bad++;
                  $display("FAIL frame_bit[%0d] seq=%s: got tx=%b busy=%b want tx=%b busy=1",
                           idx, cur_seq, tx_out, busy, exp_bit);
               end
               idx++;
            end else begin
               if (busy !== 1'b0 || tx_out !== 1'b1) begin
                  bad++;
                  $display("FAIL frame_end seq=%s: got tx=%b busy=%b want tx=1 busy=0",
                           cur_seq, tx_out, busy);
               end
               in_frame = 1'b0;
               idle_cnt = 1;
            end
         end else begin
            total++;
            if (busy !== 1'b0 || tx_out !== 1'b1) begin
               bad++;
               $display("FAIL idle_line: got tx=%b busy=%b want tx=1 busy=0", tx_out, busy);
            end
            idle_cnt++;
         end
      end
   end

   task automatic expect_frame(input string seq, input int len, input int gap);
      q_seq.push_back(seq);
      q_len.push_back(len);
      q_gap.push_back(gap);
   endtask

   // Called just after a rising edge with the DUT idle; scrambles inputs after acceptance.
   task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                       input string seq, input int len = -1);
      p_data     = d;
      par_en     = pe;
      par_typ    = pt;
      data_valid = 1'b1;
      expect_frame(seq, (len < 0) ? seq.len() * CPB : len, -1);
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      p_data     = ~d;
      par_en     = ~pe;
      par_typ    = ~pt;
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk);
         #1;
         if (!busy) done = 1'b1;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s_timeout: got busy=1 after 300 cycles want busy=0", name);
      end
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // 0xA5 even parity, 44 busy cycles.
      send(8'hA5, 1'b1, 1'b0, "01010010101");
      wait_idle("a5_even");
      // 0x01 odd then even parity.
      send(8'h01, 1'b1, 1'b1, "01000000001");
      wait_idle("01_odd");
      send(8'h01, 1'b1, 1'b0, "01000000011");
      wait_idle("01_even");
      // 0xFF without a parity slot, 40 busy cycles.
      send(8'hFF, 1'b0, 1'b0, "0111111111");
      wait_idle("ff_nopar");
      repeat (3) @(posedge clk);
      #1;

      // Held request: back-to-back frames with exactly one idle cycle between them.
      p_data     = 8'h3C;
      par_en     = 1'b1;
      par_typ    = 1'b1;
      data_valid = 1'b1;
      expect_frame("00011110011", 11 * CPB, -1);
      expect_frame("00011110011", 11 * CPB, 1);
      expect_frame("01100001111", 11 * CPB, 1);
      @(posedge clk);
      repeat (65) @(posedge clk);
      #1;
      p_data = 8'hC3;
      repeat (45) @(posedge clk);
      #1;
      data_valid = 1'b0;
      p_data     = 8'h00;
      wait_idle("b2b");
      repeat (3) @(posedge clk);
      #1;

      // Reset during the third data bit of 0x55: 14 busy cycles then idle.
      send(8'h55, 1'b0, 1'b0, "0101", 14);
      repeat (13) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(8'h55, 1'b1, 1'b0, "01010101001");
      wait_idle("55_after_rst");

      repeat (5) @(posedge clk);
      #1;
      total++;
      if (q_seq.size() != 0) begin
         bad++;
         $display("FAIL frames_missing: got %0d frames unsent want 0", q_seq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
